// File: rtl/bar_field_pkg.sv
// Shared types for the bar field sequencer: per-slot payload, the published bar word,
// and the sequencer state encoding.
package bar_field_pkg;

  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned NUM_SLOTS = 7;
  localparam int unsigned BAR_W     = SLOT_W * NUM_SLOTS;

  typedef struct packed {
    logic       flag;
    logic [1:0] code;
  } foo_struct_t;

  // slot[k] occupies bits [3k+2:3k] of the packed word
  typedef struct packed {
    foo_struct_t [NUM_SLOTS-1:0] slot;
  } bar_struct_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIRTY   = 2'd1,
    PUBLISH = 2'd2
  } seq_state_e;

  function automatic logic slot_in_range(input logic [SLOT_W-1:0] idx);
    return 32'(idx) < NUM_SLOTS;
  endfunction

  // Replace one slot, leave every other bit untouched
  function automatic bar_struct_t bar_put(input bar_struct_t b,
                                          input logic [SLOT_W-1:0] idx,
                                          input foo_struct_t f);
    bar_struct_t r;
    r = b;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (32'(idx) == k) r.slot[3'(k)] = f;
    end
    return r;
  endfunction

endpackage

// File: rtl/bar_field_sequencer_rr_arbiter.sv
// Round-robin arbiter: scans upward from ptr_i with wrap and grants the first requester.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  int unsigned cand;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = 0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr_i) + off) % N;
      if (!gnt_valid_o && req_i[IDX_W'(cand)]) begin
        gnt_valid_o              = 1'b1;
        gnt_o[IDX_W'(cand)]      = 1'b1;
        gnt_idx_o                = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bar_field_sequencer.sv
// Collects per-requester slot writes into a shadow bar word and publishes it atomically
// on commit; arbitration is round-robin and paused while a publish is in flight.
module bar_field_sequencer
  import bar_field_pkg::*;
#(
  parameter  int unsigned      NUM_REQ   = 4,
  parameter  logic [BAR_W-1:0] RESET_BAR = '0,
  localparam int unsigned      IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*SLOT_W-1:0] req_foo,
  input  logic [NUM_REQ*SLOT_W-1:0] req_slot,
  input  logic                      commit_i,
  output logic [BAR_W-1:0]          bar_o,
  output logic                      bar_valid_o,
  output logic [IDX_W-1:0]          gnt_id_o,
  output logic                      dirty_o,
  output logic                      err_o
);

  seq_state_e        state_q;
  bar_struct_t       shadow_q, shadow_d;
  bar_struct_t       bar_q;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gnt_id_q;
  logic              bar_valid_q;
  logic              err_q;
  logic              dirty_q;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  foo_struct_t        sel_foo;
  logic [SLOT_W-1:0]  sel_slot;
  logic               wr_en;
  logic               wr_err;

  // No grants while the publish cycle is copying the shadow out
  assign arb_req = (state_q != PUBLISH) ? req_valid : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i       (arb_req),
    .ptr_i       (ptr_q),
    .gnt_o       (arb_gnt),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  assign req_ready = arb_gnt;

  always_comb begin
    sel_foo  = '0;
    sel_slot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_foo  = foo_struct_t'(req_foo[i*SLOT_W +: SLOT_W]);
        sel_slot = req_slot[i*SLOT_W +: SLOT_W];
      end
    end
  end

  // An out-of-range slot still consumes the grant but never touches the shadow
  assign wr_en  = arb_valid &&  slot_in_range(sel_slot);
  assign wr_err = arb_valid && !slot_in_range(sel_slot);

  always_comb begin
    shadow_d = shadow_q;
    ptr_d    = ptr_q;
    if (wr_en) shadow_d = bar_put(shadow_q, sel_slot, sel_foo);
    if (arb_valid) begin
      ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= bar_struct_t'(RESET_BAR);
      bar_q       <= bar_struct_t'(RESET_BAR);
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      bar_valid_q <= 1'b0;
      err_q       <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      ptr_q       <= ptr_d;
      err_q       <= wr_err;
      bar_valid_q <= 1'b0;
      if (arb_valid) gnt_id_q <= arb_idx;
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            state_q <= DIRTY;
            dirty_q <= 1'b1;
          end
        end
        DIRTY: begin
          if (commit_i) begin
            state_q <= PUBLISH;
            dirty_q <= 1'b0;
          end
        end
        PUBLISH: begin
          bar_q       <= shadow_q;
          bar_valid_q <= 1'b1;
          state_q     <= IDLE;
          dirty_q     <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          dirty_q <= 1'b0;
        end
      endcase
    end
  end

  assign bar_o       = bar_q;
  assign bar_valid_o = bar_valid_q;
  assign gnt_id_o    = gnt_id_q;
  assign dirty_o     = dirty_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_bar_field_sequencer.sv
// Bench for bar_field_sequencer: slot-array model checked every cycle plus directed literals.
module tb_bar_field_sequencer;

  localparam int          N  = 4;
  localparam logic [20:0] RB = 21'h1_2345;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_foo;
  logic [11:0] req_slot;
  logic        commit_i;
  logic [20:0] bar_o;
  logic        bar_valid_o;
  logic [1:0]  gnt_id_o;
  logic        dirty_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bar_field_sequencer #(.NUM_REQ(4), .RESET_BAR(RB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_foo     (req_foo),
    .req_slot    (req_slot),
    .commit_i    (commit_i),
    .bar_o       (bar_o),
    .bar_valid_o (bar_valid_o),
    .gnt_id_o    (gnt_id_o),
    .dirty_o     (dirty_o),
    .err_o       (err_o)
  );

  // Model: seven slot values, published word, pending flags; mode 0 idle, 1 dirty, 2 publish
  int          m_slot[7];
  logic [20:0] m_bar;
  bit          m_bv, m_err;
  int          m_gid, m_ptr, m_mode;
  bit          armed = 1'b0;

  function automatic logic [20:0] pack_shadow();
    logic [20:0] r;
    r = '0;
    for (int k = 0; k < 7; k++) r[3*k +: 3] = 3'(m_slot[k]);
    return r;
  endfunction

  function automatic int exp_grant();
    if (m_mode == 2) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = exp_grant();
    return (g < 0) ? 4'b0000 : 4'(1 << g);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) m_slot[k] = int'((RB >> (3*k)) & 21'h7);
      m_bar  = RB;
      m_bv   = 1'b0;
      m_err  = 1'b0;
      m_gid  = 0;
      m_ptr  = 0;
      m_mode = 0;
      armed  = 1'b1;
    end else if (armed) begin
      int prev, g, s;
      prev  = m_mode;
      g     = exp_grant();
      m_bv  = 1'b0;
      m_err = 1'b0;
      if (prev == 2) begin
        m_bar  = pack_shadow();
        m_bv   = 1'b1;
        m_mode = 0;
      end else begin
        if (g >= 0) begin
          s     = int'(req_slot[3*g +: 3]);
          m_gid = g;
          m_ptr = (g + 1) % N;
          if (s == 7) m_err = 1'b1;
          else begin
            m_slot[s] = int'(req_foo[3*g +: 3]);
            if (prev == 0) m_mode = 1;
          end
        end
        if (prev == 1 && commit_i) m_mode = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("m_req_ready", 32'(req_ready), 32'(exp_ready()));
      check("m_bar_o", 32'(bar_o), 32'(m_bar));
      check("m_bar_valid", 32'(bar_valid_o), 32'(m_bv));
      check("m_gnt_id", 32'(gnt_id_o), 32'(m_gid));
      check("m_dirty", 32'(dirty_o), 32'(m_mode == 1));
      check("m_err", 32'(err_o), 32'(m_err));
    end
  end

  task automatic drive(input logic r, input logic [3:0] v, input logic [11:0] f,
                       input logic [11:0] s, input logic c);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_foo   = f;
    req_slot  = s;
    commit_i  = c;
    @(negedge clk);
    #1;
  endtask

  int exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1; req_valid = '0; req_foo = '0; req_slot = '0; commit_i = 1'b0;
    drive(1, 4'h0, 12'h0, 12'h0, 0);
    drive(1, 4'h0, 12'h0, 12'h0, 0);

    // Reset values
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    check("rst_bar", 32'(bar_o), 32'(21'h1_2345));
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_dirty", 32'(dirty_o), 32'h0);
    check("rst_bar_valid", 32'(bar_valid_o), 32'h0);
    check("rst_gnt_id", 32'(gnt_id_o), 32'h0);

    // Single write to slot 5 then commit
    drive(0, 4'b0001, 12'h005, 12'h005, 0);
    check("t2_ready", 32'(req_ready), 32'h1);
    drive(0, 4'h0, 12'h0, 12'h0, 1);
    check("t2_dirty", 32'(dirty_o), 32'h1);
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    check("t2_no_early_valid", 32'(bar_valid_o), 32'h0);
    check("t2_bar_held", 32'(bar_o), 32'(21'h1_2345));
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    check("t2_bar", 32'(bar_o), 32'(21'h2_A345));
    check("t2_slot5", 32'(bar_o[17:15]), 32'h5);
    check("t2_bar_valid", 32'(bar_valid_o), 32'h1);
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    check("t2_valid_pulse", 32'(bar_valid_o), 32'h0);

    // All four requesting: rotation 0,1,2,3,0
    drive(1, 4'h0, 12'h0, 12'h0, 0);
    for (int j = 0; j < 5; j++) begin
      drive(0, 4'hF, {3'd4, 3'd3, 3'd2, 3'd1}, {3'd3, 3'd2, 3'd1, 3'd0}, 0);
      check("t3_ready", 32'(req_ready), 32'(1 << exp_seq[j]));
      if (j > 0) check("t3_gnt_id", 32'(gnt_id_o), 32'(exp_seq[j-1]));
    end

    // Write in the commit cycle is included in the publish
    drive(0, 4'b0100, 12'h1C0, 12'h000, 1);
    check("t4_gnt_id", 32'(gnt_id_o), 32'h0);
    check("t4_ready", 32'(req_ready), 32'h4);
    drive(0, 4'hF, 12'h0, 12'h0, 0);
    check("t4_publish_ready", 32'(req_ready), 32'h0);
    check("t4_gnt_id2", 32'(gnt_id_o), 32'h2);
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    check("t4_bar", 32'(bar_o), 32'(21'h1_28D7));
    check("t4_slot0", 32'(bar_o[2:0]), 32'h7);
    check("t4_bar_valid", 32'(bar_valid_o), 32'h1);

    // Slot 7 write is dropped; commit in idle is ignored
    drive(0, 4'b0010, 12'h018, 12'h038, 0);
    check("t5_ready", 32'(req_ready), 32'h2);
    drive(0, 4'h0, 12'h0, 12'h0, 1);
    check("t5_err", 32'(err_o), 32'h1);
    check("t5_gnt_id", 32'(gnt_id_o), 32'h1);
    check("t5_dirty", 32'(dirty_o), 32'h0);
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    check("t5_err_pulse", 32'(err_o), 32'h0);
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    check("t5_no_publish", 32'(bar_valid_o), 32'h0);
    check("t5_bar", 32'(bar_o), 32'(21'h1_28D7));

    // Reset during the publish cycle
    drive(0, 4'b0001, 12'h003, 12'h006, 0);
    check("t6_ready", 32'(req_ready), 32'h1);
    drive(0, 4'h0, 12'h0, 12'h0, 1);
    check("t6_dirty", 32'(dirty_o), 32'h1);
    drive(1, 4'h0, 12'h0, 12'h0, 0);
    check("t6_in_publish", 32'(dirty_o), 32'h0);
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    check("t6_bar", 32'(bar_o), 32'(21'h1_2345));
    check("t6_no_valid", 32'(bar_valid_o), 32'h0);
    check("t6_dirty_clr", 32'(dirty_o), 32'h0);
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    check("t6_no_valid2", 32'(bar_valid_o), 32'h0);
    check("t6_bar2", 32'(bar_o), 32'(21'h1_2345));

    // Mixed traffic checked against the model only
    for (int j = 0; j < 80; j++) begin
      drive(0, 4'($urandom), 12'($urandom), 12'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    drive(0, 4'h0, 12'h0, 12'h0, 1);
    drive(0, 4'h0, 12'h0, 12'h0, 0);
    drive(0, 4'h0, 12'h0, 12'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
